// File: rtl/edge_frame_spi_tx_if.sv
// ----------------------------------------------------------------------------
// edge_frame_spi_tx_if
// Frame-buffer read port used by the edge-frame SPI transmitter.
//
// Handshake: the master raises rdReq and holds rdReq high with rdAddress
// stable until the slave answers with rdValid. rdValid is a single-cycle
// acknowledge and qualifies rdData in that same cycle.
//
// Signals
//   rdReq      master -> slave  read request
//   rdAddress  master -> slave  {y[8:0], x[9:0]} of the requested pixel
//   rdData     slave -> master  2-bit edge value
//   rdValid    slave -> master  one-cycle read acknowledge
// ----------------------------------------------------------------------------
interface edge_frame_spi_tx_if;
    logic        rdReq;
    logic [18:0] rdAddress;
    logic [1:0]  rdData;
    logic        rdValid;

    modport master (
        output rdReq,
        output rdAddress,
        input  rdData,
        input  rdValid
    );

    modport slave (
        input  rdReq,
        input  rdAddress,
        output rdData,
        output rdValid
    );
endinterface

// File: rtl/edge_frame_spi_tx.sv
// ----------------------------------------------------------------------------
// edge_frame_spi_tx
// SPI-peripheral transmitter returning the edge-detected frame to the MCU.
// Pixels are fetched in raster order from the frame buffer, packed four per
// byte (first pixel in bits [7:6]) and shifted out MSB-first in SPI mode 0.
// spiClk and ncs are oversampled in mainClk (mainClk >= 8x spiClk).
//
// Optional feature: READBACK_FRAMECNT_EN adds a 4-bit frame counter and makes
// the preamble byte {4'hA, frameCnt}; without it the preamble byte is 0x00.
//
// Ports
//   mainClk    in   sole clock, rising edge
//   nreset     in   asynchronous active-low reset
//   spiClk     in   SPI clock from the MCU (sampled, not a clock)
//   ncs        in   SPI chip select, active low (sampled)
//   sdo        out  serial data to the MCU
//   rdPort     if   frame-buffer read port (master side)
//   busy       out  1 while synchronized ncs is low
//   frameDone  out  one-cycle pulse when the last pixel of a frame is accepted
//   underrun   out  sticky: a byte boundary found no packed byte ready
//   dbgState   out  fetch FSM state (0 IDLE, 1 REQ, 2 FULL)
// ----------------------------------------------------------------------------
module edge_frame_spi_tx #(
    parameter int H_PIXELS    = 640,
    parameter int V_PIXELS    = 480,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       mainClk,
    input  logic                       nreset,
    input  logic                       spiClk,
    input  logic                       ncs,
    output logic                       sdo,
    edge_frame_spi_tx_if.master        rdPort,
    output logic                       busy,
    output logic                       frameDone,
    output logic                       underrun,
    output logic [1:0]                 dbgState
);

    localparam logic [9:0] X_LAST = 10'(H_PIXELS - 1);
    localparam logic [8:0] Y_LAST = 9'(V_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } fetchStateT;

    fetchStateT state, nextState;

    logic [SYNC_STAGES-1:0] spiClkSync, ncsSync;
    logic                   spiClkDly, ncsDly;
    logic                   spiClkNow, ncsNow;
    logic                   spiFall, ncsFall, ncsRise;

    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] k;
    logic [7:0] packBuf;
    logic       bufValid;
    logic [7:0] shiftReg;
    logic [2:0] bitCnt;
    logic [7:0] preamble;
    logic       accept;

    // Synchronizers; the extra delay flop gives edge detection. ncs resets
    // high so the block comes out of reset deselected.
    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            spiClkSync <= '0;
            ncsSync    <= '1;
            spiClkDly  <= 1'b0;
            ncsDly     <= 1'b1;
        end else begin
            spiClkSync <= {spiClkSync[SYNC_STAGES-2:0], spiClk};
            ncsSync    <= {ncsSync[SYNC_STAGES-2:0], ncs};
            spiClkDly  <= spiClkNow;
            ncsDly     <= ncsNow;
        end
    end

    assign spiClkNow = spiClkSync[SYNC_STAGES-1];
    assign ncsNow    = ncsSync[SYNC_STAGES-1];
    assign spiFall   = ~spiClkNow & spiClkDly;
    assign ncsFall   = ~ncsNow & ncsDly;
    assign ncsRise   = ncsNow & ~ncsDly;

    // busy is already low in the ncs-rise cycle, so a coincident spiClk
    // fall never shifts.
    assign busy = ~ncsNow;
    assign sdo  = busy ? shiftReg[7] : 1'b0;

`ifdef READBACK_FRAMECNT_EN
    logic [3:0] frameCnt;

    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset)
            frameCnt <= 4'd0;
        else if (frameDone)
            frameCnt <= frameCnt + 4'd1;
    end

    assign preamble = {4'hA, frameCnt};
`else
    assign preamble = 8'h00;
`endif

    // A pixel is taken only in REQ; chip-select edges take priority.
    assign accept = (state == REQ) && rdPort.rdValid && !ncsRise && !ncsFall;

    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (ncsRise) begin
            nextState = IDLE;
        end else if (ncsFall) begin
            nextState = REQ;
        end else begin
            case (state)
                IDLE:    nextState = IDLE;
                REQ:     if (accept && k == 2'd3) nextState = FULL;
                // The cycle after the byte is consumed, start the next one.
                FULL:    if (!bufValid) nextState = REQ;
                default: nextState = IDLE;
            endcase
        end
    end

    assign rdPort.rdReq     = (state == REQ);
    assign rdPort.rdAddress = {y, x};
    assign dbgState         = state;

    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            x         <= 10'd0;
            y         <= 9'd0;
            k         <= 2'd0;
            packBuf   <= 8'h00;
            bufValid  <= 1'b0;
            shiftReg  <= 8'h00;
            bitCnt    <= 3'd0;
            underrun  <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            if (ncsFall) begin
                x        <= 10'd0;
                y        <= 9'd0;
                k        <= 2'd0;
                bufValid <= 1'b0;
                bitCnt   <= 3'd0;
                underrun <= 1'b0;
                shiftReg <= preamble;
            end else begin
                if (accept) begin
                    case (k)
                        2'd0:    packBuf[7:6] <= rdPort.rdData;
                        2'd1:    packBuf[5:4] <= rdPort.rdData;
                        2'd2:    packBuf[3:2] <= rdPort.rdData;
                        default: packBuf[1:0] <= rdPort.rdData;
                    endcase
                    k <= k + 2'd1;
                    if (k == 2'd3)
                        bufValid <= 1'b1;
                    if (x == X_LAST) begin
                        x <= 10'd0;
                        if (y == Y_LAST) begin
                            y         <= 9'd0;
                            frameDone <= 1'b1;
                        end else begin
                            y <= y + 9'd1;
                        end
                    end else begin
                        x <= x + 10'd1;
                    end
                end
                // bufValid is only ever set in REQ, where it is already 0,
                // so set and consume cannot collide.
                if (busy && spiFall) begin
                    bitCnt <= bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        if (bufValid) begin
                            shiftReg <= packBuf;
                            bufValid <= 1'b0;
                        end else begin
                            shiftReg <= 8'h00;
                            underrun <= 1'b1;
                        end
                    end else begin
                        shiftReg <= {shiftReg[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_frame_spi_tx.sv
// ----------------------------------------------------------------------------
// tb_edge_frame_spi_tx
// Directed bench for edge_frame_spi_tx on a small 8x4 frame. The frame-buffer
// model answers one cycle after a request with x[1:0]^y[1:0], so row 0 reads
// 0x1B per byte while later rows give distinct bytes.
// ----------------------------------------------------------------------------
module tb_edge_frame_spi_tx;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int SYNC = 2;

`ifdef READBACK_FRAMECNT_EN
    localparam logic [3:0] PRE_HI     = 4'hA;
    localparam bit         PRE_CNT_EN = 1'b1;
`else
    localparam logic [3:0] PRE_HI     = 4'h0;
    localparam bit         PRE_CNT_EN = 1'b0;
`endif

    logic       mainClk = 1'b0;
    logic       nreset  = 1'b0;
    logic       spiClk  = 1'b0;
    logic       ncs     = 1'b1;
    logic       sdo, busy, frameDone, underrun;
    logic [1:0] dbgState;
    logic       stall   = 1'b0;

    int checks = 0;
    int errors = 0;

    int          fdCount = 0;
    int          addrCaptures = 0;
    logic        armed = 1'b0;
    logic [18:0] addrAfterFd = '0;

    edge_frame_spi_tx_if rdIf ();

    edge_frame_spi_tx #(
        .H_PIXELS    (H),
        .V_PIXELS    (V),
        .SYNC_STAGES (SYNC)
    ) dut (
        .mainClk   (mainClk),
        .nreset    (nreset),
        .spiClk    (spiClk),
        .ncs       (ncs),
        .sdo       (sdo),
        .rdPort    (rdIf),
        .busy      (busy),
        .frameDone (frameDone),
        .underrun  (underrun),
        .dbgState  (dbgState)
    );

    // ---------------- clock ----------------
    always #5 mainClk = ~mainClk;

    // ---------------- frame-buffer model ----------------
    initial begin
        rdIf.rdValid = 1'b0;
        rdIf.rdData  = 2'd0;
        forever begin
            @(negedge mainClk);
            if (rdIf.rdReq && !rdIf.rdValid && !stall) begin
                rdIf.rdValid = 1'b1;
                rdIf.rdData  = rdIf.rdAddress[1:0] ^ rdIf.rdAddress[11:10];
            end else begin
                rdIf.rdValid = 1'b0;
            end
        end
    end

    // ---------------- frameDone monitor ----------------
    initial begin
        forever begin
            @(negedge mainClk);
            if (frameDone) begin
                fdCount++;
                armed = 1'b1;
            end else if (armed && rdIf.rdReq) begin
                addrAfterFd = rdIf.rdAddress;
                addrCaptures++;
                armed = 1'b0;
            end
        end
    end

    // ---------------- model / driver helpers ----------------
    function automatic logic [7:0] pix_byte(input int idx);
        logic [7:0] b;
        int p, px, py;
        logic [1:0] v;
        b = 8'h00;
        for (int j = 0; j < 4; j++) begin
            p  = idx * 4 + j;
            px = p % H;
            py = (p / H) % V;
            v  = 2'(px) ^ 2'(py);
            b  = {b[5:0], v};
        end
        return b;
    endfunction

    function automatic logic [7:0] exp_pre(input int frames);
        logic [3:0] lo;
        lo = PRE_CNT_EN ? 4'(frames) : 4'h0;
        return {PRE_HI, lo};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge mainClk);
    endtask

    // Mode 0: MCU samples on the rising edge, half period = 4 mainClk cycles.
    task automatic spi_bits(input int n, output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < n; i++) begin
            tick(4);
            b = {b[6:0], sdo};
            spiClk = 1'b1;
            tick(4);
            spiClk = 1'b0;
        end
    endtask

    task automatic spi_byte(output logic [7:0] b);
        spi_bits(8, b);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nreset = 1'b0;
        ncs    = 1'b1;
        spiClk = 1'b0;
        tick(10);
        checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo got=%b exp=0", sdo); end
        checks++; if (rdIf.rdReq !== 1'b0) begin errors++; $display("FAIL reset_rdReq got=%b exp=0", rdIf.rdReq); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL reset_frameDone got=%b exp=0", frameDone); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        checks++; if (rdIf.rdAddress !== 19'd0) begin errors++; $display("FAIL reset_rdAddress got=%h exp=0", rdIf.rdAddress); end
        checks++; if (dbgState !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbgState); end
        nreset = 1'b1;
        tick(3);
    endtask

    task automatic test_basic_stream();
        logic [7:0] got, exp;
        int waitCnt;
        ncs = 1'b0;
        waitCnt = 0;
        while (rdIf.rdReq !== 1'b1 && waitCnt < 20) begin tick(1); waitCnt++; end
        checks++; if (rdIf.rdReq !== 1'b1) begin errors++; $display("FAIL basic_first_req got=%b exp=1 after %0d cycles", rdIf.rdReq, waitCnt); end
        checks++; if (rdIf.rdAddress !== 19'd0) begin errors++; $display("FAIL basic_first_addr got=%h exp=0", rdIf.rdAddress); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
        for (int i = 0; i < 4; i++) begin
            spi_byte(got);
            exp = (i == 0) ? exp_pre(0) : pix_byte(i - 1);
            checks++; if (got !== exp) begin errors++; $display("FAIL basic_byte%0d got=%h exp=%h", i, got, exp); end
        end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL basic_underrun got=%b exp=0", underrun); end
        ncs = 1'b1;
        tick(6);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
        checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL basic_sdo_idle got=%b exp=0", sdo); end
    endtask

    task automatic test_underrun();
        logic [7:0] got;
        ncs = 1'b0;
        tick(2);
        spi_byte(got);
        checks++; if (got !== exp_pre(0)) begin errors++; $display("FAIL urun_preamble got=%h exp=%h", got, exp_pre(0)); end
        spi_byte(got);
        checks++; if (got !== pix_byte(0)) begin errors++; $display("FAIL urun_byte0 got=%h exp=%h", got, pix_byte(0)); end
        stall = 1'b1;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL urun_before got=%b exp=0", underrun); end
        spi_byte(got);
        checks++; if (got !== pix_byte(1)) begin errors++; $display("FAIL urun_byte1 got=%h exp=%h", got, pix_byte(1)); end
        tick(6);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL urun_flag got=%b exp=1", underrun); end
        checks++; if (rdIf.rdReq !== 1'b1) begin errors++; $display("FAIL urun_req_held got=%b exp=1", rdIf.rdReq); end
        checks++; if (rdIf.rdAddress !== 19'h00400) begin errors++; $display("FAIL urun_addr_held got=%h exp=00400", rdIf.rdAddress); end
        tick(1900);
        checks++; if (rdIf.rdAddress !== 19'h00400) begin errors++; $display("FAIL urun_addr_stable got=%h exp=00400", rdIf.rdAddress); end
        stall = 1'b0;
        tick(20);
        spi_byte(got);
        checks++; if (got !== 8'h00) begin errors++; $display("FAIL urun_zero_byte got=%h exp=00", got); end
        for (int i = 2; i < 5; i++) begin
            spi_byte(got);
            checks++; if (got !== pix_byte(i)) begin errors++; $display("FAIL urun_resume%0d got=%h exp=%h", i, got, pix_byte(i)); end
        end
        ncs = 1'b1;
        tick(6);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL urun_sticky got=%b exp=1", underrun); end
    endtask

    task automatic test_restart();
        logic [7:0] got;
        int waitCnt;
        stall = 1'b1;
        ncs = 1'b0;
        tick(6);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL restart_urun_clear got=%b exp=0", underrun); end
        spi_bits(3, got);
        checks++; if (rdIf.rdReq !== 1'b1) begin errors++; $display("FAIL restart_req_before got=%b exp=1", rdIf.rdReq); end
        ncs = 1'b1;
        waitCnt = 0;
        while (rdIf.rdReq === 1'b1 && waitCnt < 20) begin tick(1); waitCnt++; end
        checks++; if (rdIf.rdReq !== 1'b0 || waitCnt > 4) begin errors++; $display("FAIL restart_req_drop got=%b after %0d cycles exp=0 within 4", rdIf.rdReq, waitCnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_busy got=%b exp=0", busy); end
        stall = 1'b0;
        tick(4);
        ncs = 1'b0;
        waitCnt = 0;
        while (rdIf.rdReq !== 1'b1 && waitCnt < 20) begin tick(1); waitCnt++; end
        checks++; if (rdIf.rdReq !== 1'b1 || rdIf.rdAddress !== 19'd0) begin errors++; $display("FAIL restart_first_req got req=%b addr=%h exp req=1 addr=0", rdIf.rdReq, rdIf.rdAddress); end
        spi_byte(got);
        checks++; if (got !== exp_pre(0)) begin errors++; $display("FAIL restart_preamble got=%h exp=%h", got, exp_pre(0)); end
        spi_byte(got);
        checks++; if (got !== 8'h1B) begin errors++; $display("FAIL restart_byte0 got=%h exp=1b", got); end
        ncs = 1'b1;
        tick(6);
    endtask

    task automatic test_full_frame();
        logic [7:0] got;
        int fdBase, capBase;
        fdBase  = fdCount;
        capBase = addrCaptures;
        ncs = 1'b0;
        tick(2);
        spi_byte(got);
        checks++; if (got !== exp_pre(0)) begin errors++; $display("FAIL frame_preamble got=%h exp=%h", got, exp_pre(0)); end
        for (int i = 0; i < 6; i++) begin
            spi_byte(got);
            checks++; if (got !== pix_byte(i)) begin errors++; $display("FAIL frame_byte%0d got=%h exp=%h", i, got, pix_byte(i)); end
        end
        checks++; if (fdCount - fdBase !== 0) begin errors++; $display("FAIL frame_done_early got=%0d exp=0", fdCount - fdBase); end
        for (int i = 6; i < 8; i++) begin
            spi_byte(got);
            checks++; if (got !== pix_byte(i)) begin errors++; $display("FAIL frame_byte%0d got=%h exp=%h", i, got, pix_byte(i)); end
        end
        tick(6);
        checks++; if (fdCount - fdBase !== 1) begin errors++; $display("FAIL frame_done_count got=%0d exp=1", fdCount - fdBase); end
        checks++; if (addrCaptures - capBase !== 1 || addrAfterFd !== 19'd0) begin errors++; $display("FAIL frame_next_addr got captures=%0d addr=%h exp 1 capture addr=0", addrCaptures - capBase, addrAfterFd); end
        spi_byte(got);
        checks++; if (got !== 8'h1B) begin errors++; $display("FAIL frame_wrap_byte got=%h exp=1b", got); end
        checks++; if (fdCount - fdBase !== 1) begin errors++; $display("FAIL frame_done_once got=%0d exp=1", fdCount - fdBase); end
        ncs = 1'b1;
        tick(6);
    endtask

    task automatic test_frame_count();
        logic [7:0] got;
        ncs = 1'b0;
        tick(2);
        spi_byte(got);
        checks++; if (got !== exp_pre(1)) begin errors++; $display("FAIL fcnt_preamble got=%h exp=%h", got, exp_pre(1)); end
        spi_byte(got);
        checks++; if (got !== 8'h1B) begin errors++; $display("FAIL fcnt_byte0 got=%h exp=1b", got); end
        ncs = 1'b1;
        tick(6);
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        ncs = 1'b0;
        tick(2);
        spi_byte(got);
        spi_bits(3, got);
        tick(4);
        checks++; if (sdo !== 1'b1) begin errors++; $display("FAIL midrst_sdo_before got=%b exp=1", sdo); end
        nreset = 1'b0;
        #1;
        checks++; if (sdo !== 1'b0 || busy !== 1'b0 || rdIf.rdReq !== 1'b0) begin errors++; $display("FAIL midrst_outputs got sdo=%b busy=%b req=%b exp 0 0 0", sdo, busy, rdIf.rdReq); end
        checks++; if (rdIf.rdAddress !== 19'd0 || underrun !== 1'b0 || dbgState !== 2'd0) begin errors++; $display("FAIL midrst_state got addr=%h urun=%b st=%0d exp 0 0 0", rdIf.rdAddress, underrun, dbgState); end
        ncs = 1'b1;
        tick(2);
        nreset = 1'b1;
        tick(4);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic_stream();
        test_underrun();
        test_restart();
        test_full_frame();
        test_frame_count();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
